// File: rtl/cache_fill_fsm.sv
// Block-fill controller for one cache: on a miss it stalls the pipeline,
// issues one read per block word, streams returned words into the data array,
// then writes the tag.
module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int WORD_BYTES  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  input  logic                           memory_data_valid,
  input  logic [DATA_W-1:0]              memory_data,
  output logic                           fsm_busy,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              memory_address,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] write_word_idx,
  output logic [DATA_W-1:0]              fill_data,
  output logic                           write_tag_array,
  output logic                           fill_done
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int BLK_W = $clog2(BLOCK_WORDS * WORD_BYTES);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << BLK_W) - ADDR_W'(1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_TAG
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]   ret_cnt_q, ret_cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [IDX_W-1:0]   addr_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_cnt_q <= '0;
      ret_cnt_q <= '0;
      base_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      base_q    <= base_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    req_cnt_d        = req_cnt_q;
    ret_cnt_d        = ret_cnt_q;
    base_d           = base_q;
    mem_req          = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;
    addr_idx         = '0;

    case (state_q)
      S_IDLE: begin
        if (miss_detected) begin
          base_d    = miss_address & BLK_MASK;
          req_cnt_d = '0;
          ret_cnt_d = '0;
          state_d   = S_FILL;
        end
      end

      S_FILL: begin
        // Once all requests are out, the address parks on the last word.
        if (req_cnt_q < CNT_FULL) begin
          mem_req   = 1'b1;
          addr_idx  = req_cnt_q[IDX_W-1:0];
          req_cnt_d = req_cnt_q + CNT_W'(1);
        end else begin
          addr_idx  = '1;
        end

        if (memory_data_valid) begin
          write_data_array = 1'b1;
          ret_cnt_d        = ret_cnt_q + CNT_W'(1);
          if (ret_cnt_q == CNT_LAST) begin
            state_d = S_TAG;
          end
        end
      end

      S_TAG: begin
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        addr_idx        = '1;
        state_d         = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Base is block-aligned, so the offset add never carries out of the block.
  assign memory_address = base_q + (ADDR_W'(addr_idx) << OFF_W);
  assign write_word_idx = ret_cnt_q[IDX_W-1:0];
  assign fill_data      = memory_data;
  assign fsm_busy       = (state_q != S_IDLE) | miss_detected;

endmodule
